// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC multiplexed-bus controller: FSM states,
// bus phase types and status-byte bit positions.
package rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_SET = 3'd1,
    S_A_PUL = 3'd2,
    S_A_HLD = 3'd3,
    S_D_SET = 3'd4,
    S_D_PUL = 3'd5,
    S_D_HLD = 3'd6
  } rtc_state_t;

  typedef enum logic [1:0] {
    PH_ADDR = 2'd0,
    PH_RD   = 2'd1,
    PH_WR   = 2'd2
  } rtc_phase_t;

  localparam int STAT_BUSY    = 7;
  localparam int STAT_OVERRUN = 6;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic is_addr_state(rtc_state_t s);
    return (s == S_A_SET) || (s == S_A_PUL) || (s == S_A_HLD);
  endfunction

  function automatic logic is_pulse_state(rtc_state_t s);
    return (s == S_A_PUL) || (s == S_D_PUL);
  endfunction

  // Bus phase type seen on the pins: address phase, else the latched operation.
  function automatic rtc_phase_t phase_of(rtc_state_t s, rtc_phase_t op);
    return is_addr_state(s) ? PH_ADDR : op;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; done is high on the last
// cycle of the phase.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Turns single-cycle processor port writes into timed address + read/write
// cycles on the RTC chip's multiplexed bus; returns read data and status.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       act,
  input  logic       dir,
  input  logic       wr_stb,
  input  logic       rd_stb,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       rtc_cs_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic       rtc_ad,
  inout  wire  [7:0] rtc_data
);

  localparam int CNT_W = $clog2(max3(T_SETUP, T_PULSE, T_HOLD)) + 1;

  rtc_state_t       state, state_next;
  rtc_phase_t       op_q, op_next, ph_next;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       wdata_reg, wdata_next;
  logic [7:0]       rdata_reg;
  logic             overrun, overrun_next;
  logic             sample_rd;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmp_val;

  // Registered pin drivers, computed from the next state so pins change
  // cleanly on the clock edge together with the FSM.
  logic       bus_oe;
  logic [7:0] bus_q;
  logic       txn_next;
  logic       cs_n_next, rd_n_next, wr_n_next, ad_next, oe_next;
  logic [7:0] bus_next;
  logic [7:0] status;

  // Reads have no side effects, so the read strobe carries no information here.
  logic unused_rd_stb;
  assign unused_rd_stb = rd_stb;

  function automatic logic [CNT_W-1:0] reload_of(rtc_state_t s);
    case (s)
      S_A_SET, S_D_SET: return CNT_W'(T_SETUP - 1);
      S_A_PUL, S_D_PUL: return CNT_W'(T_PULSE - 1);
      S_A_HLD, S_D_HLD: return CNT_W'(T_HOLD - 1);
      default:          return '0;
    endcase
  endfunction

  rtc_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmp_val),
    .done     (tmr_done)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    op_next      = op_q;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    overrun_next = overrun;
    sample_rd    = 1'b0;

    if (state == S_IDLE) begin
      if (act && wr_stb) begin
        overrun_next = 1'b0;
        op_next      = dir ? PH_WR : PH_RD;
        if (dir) wdata_next = din;
        else     addr_next  = din;
        state_next   = S_A_SET;
      end
    end else begin
      if (act && wr_stb) overrun_next = 1'b1;
      if (tmr_done) begin
        case (state)
          S_A_SET: state_next = S_A_PUL;
          S_A_PUL: state_next = S_A_HLD;
          S_A_HLD: state_next = S_D_SET;
          S_D_SET: state_next = S_D_PUL;
          S_D_PUL: begin
            state_next = S_D_HLD;
            sample_rd  = (op_q == PH_RD);
          end
          default: state_next = S_IDLE;
        endcase
      end
    end

    tmr_load = (state_next != state);
    tmp_val  = reload_of(state_next);

    txn_next  = (state_next != S_IDLE);
    ph_next   = phase_of(state_next, op_next);
    cs_n_next = !txn_next;
    ad_next   = txn_next && (ph_next == PH_ADDR);
    oe_next   = txn_next && (ph_next != PH_RD);
    wr_n_next = !(is_pulse_state(state_next) && (ph_next != PH_RD));
    rd_n_next = !(is_pulse_state(state_next) && (ph_next == PH_RD));
    bus_next  = (ph_next == PH_ADDR) ? addr_next : wdata_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= PH_RD;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      rtc_cs_n  <= 1'b1;
      rtc_rd_n  <= 1'b1;
      rtc_wr_n  <= 1'b1;
      rtc_ad    <= 1'b0;
      bus_oe    <= 1'b0;
      bus_q     <= '0;
    end else begin
      state     <= state_next;
      op_q      <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      overrun   <= overrun_next;
      if (sample_rd) rdata_reg <= rtc_data;
      busy      <= txn_next;
      rtc_cs_n  <= cs_n_next;
      rtc_rd_n  <= rd_n_next;
      rtc_wr_n  <= wr_n_next;
      rtc_ad    <= ad_next;
      bus_oe    <= oe_next;
      bus_q     <= bus_next;
    end
  end

  assign rtc_data = bus_oe ? bus_q : 'z;

  always_comb begin
    status                = '0;
    status[STAT_BUSY]     = busy;
    status[STAT_OVERRUN]  = overrun;
  end

  assign dout = dir ? rdata_reg : status;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Randomized bench for rtc_bus_ctrl: a default-timing instance and a
// minimum-timing instance, both checked cycle by cycle against a pin-trace model.
module tb_rtc_bus_ctrl;

  localparam int TS0 = 2, TP0 = 4, TH0 = 2;
  localparam int TS1 = 1, TP1 = 1, TH1 = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       act, dir, wr_stb, rd_stb;
  logic [7:0] din;
  logic       sel;
  logic [7:0] chip_val;

  logic       act0, act1;
  logic [7:0] dout0, dout1;
  logic       busy0, busy1, cs_n0, cs_n1, rd_n0, rd_n1, wr_n0, wr_n1, ad0, ad1;
  wire  [7:0] bus0, bus1;

  assign act0 = act && !sel;
  assign act1 = act && sel;

  // RTC chip model: drives the bus only while the controller's read strobe is low.
  assign bus0 = !rd_n0 ? chip_val : 'z;
  assign bus1 = !rd_n1 ? chip_val : 'z;

  rtc_bus_ctrl #(.T_SETUP(TS0), .T_PULSE(TP0), .T_HOLD(TH0)) dut (
    .clk(clk), .reset(reset), .act(act0), .dir(dir), .wr_stb(wr_stb),
    .rd_stb(rd_stb), .din(din), .dout(dout0), .busy(busy0),
    .rtc_cs_n(cs_n0), .rtc_rd_n(rd_n0), .rtc_wr_n(wr_n0), .rtc_ad(ad0),
    .rtc_data(bus0)
  );

  rtc_bus_ctrl #(.T_SETUP(TS1), .T_PULSE(TP1), .T_HOLD(TH1)) dut_min (
    .clk(clk), .reset(reset), .act(act1), .dir(dir), .wr_stb(wr_stb),
    .rd_stb(rd_stb), .din(din), .dout(dout1), .busy(busy1),
    .rtc_cs_n(cs_n1), .rtc_rd_n(rd_n1), .rtc_wr_n(wr_n1), .rtc_ad(ad1),
    .rtc_data(bus1)
  );

  wire       oe0 = dut.bus_oe;
  wire       oe1 = dut_min.bus_oe;
  wire [5:0] obs_ctl  = sel ? {busy1, cs_n1, rd_n1, wr_n1, ad1, oe1}
                            : {busy0, cs_n0, rd_n0, wr_n0, ad0, oe0};
  wire [7:0] obs_data = sel ? bus1 : bus0;
  wire [7:0] obs_dout = sel ? dout1 : dout0;

  localparam logic [5:0] CTL_IDLE = 6'b011100;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_addr  [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2];
  logic       m_ovr   [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0; m_ovr[i] = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted command on the selected instance, checked every cycle.
  // inj > 0 issues a discarded command just before edge inj of the transaction;
  // chip_fixed >= 0 holds the chip's read data constant, else it changes every cycle.
  task automatic run_txn(input logic d, input logic [7:0] data, input int inj,
                         input int chip_fixed);
    int         s, ts, tp, th, len;
    logic [7:0] exp_rdata;
    logic [5:0] exp_ctl;
    logic [7:0] exp_data, exp_stat;
    logic       dp, pul, e_oe;
    int         o;
    s  = int'(sel);
    ts = sel ? TS1 : TS0;
    tp = sel ? TP1 : TP0;
    th = sel ? TH1 : TH0;
    len = ts + tp + th;
    exp_rdata = m_rdata[s];

    dir = d; din = data; act = 1'b1; wr_stb = 1'b1;
    tick();
    act = 1'b0; wr_stb = 1'b0; dir = 1'b0; din = 8'($urandom);
    m_ovr[s] = 1'b0;
    if (d) m_wdata[s] = data;
    else   m_addr[s]  = data;

    for (int c = 0; c < 2 * len; c++) begin
      chip_val = (chip_fixed >= 0) ? 8'(chip_fixed) : 8'($urandom);
      rd_stb   = 1'($urandom);
      #1;
      dp   = (c >= len);
      o    = c % len;
      pul  = (o >= ts) && (o < ts + tp);
      e_oe = !dp || d;
      exp_ctl  = {1'b1, 1'b0, !(pul && dp && !d), !(pul && (!dp || d)), !dp, e_oe};
      exp_data = dp ? m_wdata[s] : m_addr[s];
      exp_stat = {1'b1, m_ovr[s], 6'b0};
      if (dp && !d && (o == ts + tp - 1)) exp_rdata = chip_val;

      checks++;
      if (obs_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL ctl sel=%0d cyc=%0d got=%b exp=%b (busy,cs_n,rd_n,wr_n,ad,oe)",
                 s, c, obs_ctl, exp_ctl);
      end
      checks++;
      if (obs_dout !== exp_stat) begin
        errors++;
        $display("FAIL status sel=%0d cyc=%0d got=%h exp=%h", s, c, obs_dout, exp_stat);
      end
      if (e_oe) begin
        checks++;
        if (obs_data !== exp_data) begin
          errors++;
          $display("FAIL bus_drive sel=%0d cyc=%0d got=%h exp=%h", s, c, obs_data, exp_data);
        end
      end else if (pul) begin
        checks++;
        if (obs_data !== chip_val) begin
          errors++;
          $display("FAIL bus_read sel=%0d cyc=%0d got=%h exp=%h", s, c, obs_data, chip_val);
        end
      end

      if (inj > 0 && c + 1 == inj) begin
        act = 1'b1; wr_stb = 1'b1; dir = 1'($urandom); din = 8'($urandom);
      end
      tick();
      if (inj > 0 && c + 1 == inj) begin
        act = 1'b0; wr_stb = 1'b0; dir = 1'b0;
        m_ovr[s] = 1'b1;
      end
    end

    if (!d) m_rdata[s] = exp_rdata;
    checks++;
    if (obs_ctl !== CTL_IDLE) begin
      errors++;
      $display("FAIL end_ctl sel=%0d got=%b exp=%b", s, obs_ctl, CTL_IDLE);
    end
    #1;
    checks++;
    if (obs_dout !== {1'b0, m_ovr[s], 6'b0}) begin
      errors++;
      $display("FAIL end_status sel=%0d got=%h exp=%h", s, obs_dout, {1'b0, m_ovr[s], 6'b0});
    end
    dir = 1'b1;
    #1;
    checks++;
    if (obs_dout !== m_rdata[s]) begin
      errors++;
      $display("FAIL rdata sel=%0d got=%h exp=%h", s, obs_dout, m_rdata[s]);
    end
    dir = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 1'b0; dir = 1'b0;
    model_reset();
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      #1;
      checks++;
      if (obs_ctl !== 6'b011100) begin
        errors++;
        $display("FAIL reset_ctl sel=%0d got=%b exp=%b", i, obs_ctl, 6'b011100);
      end
      checks++;
      if (obs_dout !== 8'h00) begin
        errors++;
        $display("FAIL reset_status sel=%0d got=%h exp=00", i, obs_dout);
      end
    end
    sel = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  // Reset asserted in the middle of the read pulse must drop everything at once.
  task automatic test_reset_mid();
    int stop;
    sel = 1'b0;
    chip_val = 8'hA5;
    dir = 1'b0; din = 8'($urandom); act = 1'b1; wr_stb = 1'b1;
    tick();
    act = 1'b0; wr_stb = 1'b0;
    stop = TS0 + TP0 + TH0 + TS0 + 1;
    for (int c = 0; c < stop; c++) tick();
    checks++;
    if (rd_n0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rd_pulse got=%b exp=0", rd_n0);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy0, cs_n0, rd_n0, wr_n0, ad0, oe0} !== CTL_IDLE) begin
      errors++;
      $display("FAIL mid_reset_ctl got=%b exp=%b",
               {busy0, cs_n0, rd_n0, wr_n0, ad0, oe0}, CTL_IDLE);
    end
    dir = 1'b1;
    #1;
    checks++;
    if (dout0 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_rdata got=%h exp=00", dout0);
    end
    dir = 1'b0;
    model_reset();
    tick();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({busy0, cs_n0, rd_n0, wr_n0, ad0, oe0} !== CTL_IDLE) begin
      errors++;
      $display("FAIL post_reset_ctl got=%b exp=%b",
               {busy0, cs_n0, rd_n0, wr_n0, ad0, oe0}, CTL_IDLE);
    end
  endtask

  task automatic test_read();
    sel = 1'b0;
    run_txn(1'b0, 8'h21, 0, 8'h59);
    checks++;
    if (m_rdata[0] !== 8'h59) begin
      errors++;
      $display("FAIL read_value got=%h exp=59", m_rdata[0]);
    end
  endtask

  task automatic test_write();
    sel = 1'b0;
    run_txn(1'b0, 8'h22, 0, -1);
    run_txn(1'b1, 8'h07, 0, -1);
  endtask

  task automatic test_overrun();
    sel = 1'b0;
    run_txn(1'b1, 8'($urandom), 3, -1);
    run_txn(1'b0, 8'($urandom), 0, -1);
  endtask

  task automatic test_min_timing();
    sel = 1'b1;
    run_txn(1'b0, 8'($urandom), 0, -1);
    run_txn(1'b1, 8'($urandom), 0, -1);
    run_txn(1'b1, 8'($urandom), 2, -1);
    run_txn(1'b0, 8'($urandom), 6, -1);
    sel = 1'b0;
  endtask

  // Processor writes to other blocks (act=0) must leave the controller untouched.
  task automatic test_no_act();
    sel = 1'b0;
    act = 1'b0;
    for (int c = 0; c < 8; c++) begin
      wr_stb = 1'b1; dir = 1'($urandom); din = 8'($urandom); rd_stb = 1'($urandom);
      tick();
      wr_stb = 1'b0; dir = 1'b0;
      #1;
      checks++;
      if (obs_ctl !== CTL_IDLE || obs_dout !== {1'b0, m_ovr[0], 6'b0}) begin
        errors++;
        $display("FAIL no_act cyc=%0d ctl=%b status=%h exp_ctl=%b exp_status=%h",
                 c, obs_ctl, obs_dout, CTL_IDLE, {1'b0, m_ovr[0], 6'b0});
      end
    end
    run_txn(1'b1, 8'($urandom), 0, -1);
  endtask

  task automatic test_random();
    logic d;
    int   s, len, inj;
    for (int n = 0; n < 24; n++) begin
      s   = int'($urandom_range(1, 0));
      sel = 1'(s);
      len = s ? (TS1 + TP1 + TH1) : (TS0 + TP0 + TH0);
      d   = 1'($urandom);
      inj = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2 * len, 1)) : 0;
      run_txn(d, 8'($urandom), inj, -1);
    end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    act = 1'b0; dir = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0; din = '0;
    sel = 1'b0; chip_val = '0; reset = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_overrun();
    test_min_timing();
    test_no_act();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
